// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer for the ARM core.
//
// Walks one instruction through NUM_STAGES sequential stages, raising one
// stage enable per cycle. Stages can be skipped per instruction, a taken
// branch can jump forward to FLUSH_TARGET, the sequence can stall between
// stages, and the core can be halted at an instruction boundary.
//
// Ports:
//   clk_i                 system clock
//   nreset_i              synchronous reset, active-high despite the name
//   stall_i               hold at the next stage boundary
//   flush_i               branch taken; jump forward to FLUSH_TARGET
//   skip_mask_i           stages to bypass for the current instruction (bit 0 ignored)
//   halt_req_i            stop at the next instruction boundary
//   stage_go_o            one-hot stage clock enable
//   stage_idx_o           current (or held) stage index
//   instr_done_o          one-cycle pulse after an instruction retires
//   halted_o              sequencer is halted
//   retired_count_o       retired instruction count, wraps
//   last_instr_cycles_o   cycle count of the most recently retired instruction
module stage_sequencer #(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned FLUSH_TARGET = NUM_STAGES - 1,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned IDX_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [NUM_STAGES-1:0] skip_mask_i,
    input  logic                  halt_req_i,
    output logic [NUM_STAGES-1:0] stage_go_o,
    output logic [IDX_W-1:0]      stage_idx_o,
    output logic                  instr_done_o,
    output logic                  halted_o,
    output logic [CNT_W-1:0]      retired_count_o,
    output logic [CNT_W-1:0]      last_instr_cycles_o
);

    localparam logic [IDX_W-1:0]      FlushIdx = IDX_W'(FLUSH_TARGET);
    localparam logic [IDX_W-1:0]      LastIdx  = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] GoStage0 = NUM_STAGES'(1);

    typedef enum logic [1:0] {StStart, StRun, StStall, StHalted} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;

    logic [IDX_W-1:0] skip_next;
    logic             skip_found;
    logic             do_flush;
    logic             retire;
    logic [CNT_W-1:0] cyc_inc;

    // Fetch always runs, so its skip bit has no meaning.
    logic unused_skip0;
    assign unused_skip0 = skip_mask_i[0];

    always_comb begin
        // Lowest non-skipped stage above the current one; scanning downward
        // lets the last hit win.
        skip_next  = '0;
        skip_found = 1'b0;
        for (int j = NUM_STAGES - 1; j >= 1; j--) begin
            if ((IDX_W'(j) > idx_q) && !skip_mask_i[j]) begin
                skip_found = 1'b1;
                skip_next  = IDX_W'(j);
            end
        end

        // A flush can only move forward; otherwise it is dropped.
        do_flush = flush_i && (FlushIdx > idx_q);
        retire   = !do_flush && (!skip_found || (idx_q == LastIdx));
        cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);

        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        retired_d = retired_q;
        last_d    = last_q;
        cyc_d     = cyc_q;

        case (state_q)
            StStart: begin
                state_d = StRun;
                idx_d   = '0;
            end
            StRun: begin
                if (retire) begin
                    retired_d = retired_q + CNT_W'(1);
                    last_d    = cyc_q + CNT_W'(1);
                    cyc_d     = '0;
                    done_d    = 1'b1;
                    idx_d     = '0;
                    // Halt wins over stall at a retire boundary.
                    state_d   = halt_req_i ? StHalted : StRun;
                end else begin
                    cyc_d   = cyc_inc;
                    idx_d   = do_flush ? FlushIdx : skip_next;
                    state_d = stall_i ? StStall : StRun;
                end
            end
            StStall: begin
                cyc_d = cyc_inc;
                if (!stall_i) begin
                    state_d = StRun;
                end
            end
            StHalted: begin
                idx_d = '0;
                if (!halt_req_i) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StStart;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (nreset_i) begin
            state_q   <= StStart;
            idx_q     <= '0;
            done_q    <= 1'b0;
            retired_q <= '0;
            last_q    <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            retired_q <= retired_d;
            last_q    <= last_d;
            cyc_q     <= cyc_d;
        end
    end

    // Decoded from registers only; no input reaches an output combinationally.
    assign stage_go_o          = (state_q == StRun) ? (GoStage0 << idx_q) : '0;
    assign stage_idx_o         = idx_q;
    assign instr_done_o        = done_q;
    assign halted_o            = (state_q == StHalted);
    assign retired_count_o     = retired_q;
    assign last_instr_cycles_o = last_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus randomized stimulus,
// both checked against a behavioural model. A second instance with 4-bit
// counters exercises counter wrap and saturation.
module tb_stage_sequencer;

    localparam int N  = 5;
    localparam int FT = N - 1;

    localparam int MStart = 0;
    localparam int MRun   = 1;
    localparam int MStall = 2;
    localparam int MHalt  = 3;

    logic         clk;
    logic         nreset;
    logic         stall;
    logic         flush;
    logic [N-1:0] skip_mask;
    logic         halt_req;

    logic [N-1:0] go,   go4;
    logic [2:0]   idx,  idx4;
    logic         done, done4;
    logic         halted, halted4;
    logic [15:0]  ret, last;
    logic [3:0]   ret4, last4;

    int checks;
    int errors;

    // Behavioural model
    int m_mode;
    int m_idx;
    int m_done;
    int m_ret;
    int m_cyc16, m_cyc4;
    int m_last16, m_last4;

    stage_sequencer #(.NUM_STAGES(N)) dut (
        .clk_i               (clk),
        .nreset_i            (nreset),
        .stall_i             (stall),
        .flush_i             (flush),
        .skip_mask_i         (skip_mask),
        .halt_req_i          (halt_req),
        .stage_go_o          (go),
        .stage_idx_o         (idx),
        .instr_done_o        (done),
        .halted_o            (halted),
        .retired_count_o     (ret),
        .last_instr_cycles_o (last)
    );

    stage_sequencer #(.NUM_STAGES(N), .CNT_W(4)) dut4 (
        .clk_i               (clk),
        .nreset_i            (nreset),
        .stall_i             (stall),
        .flush_i             (flush),
        .skip_mask_i         (skip_mask),
        .halt_req_i          (halt_req),
        .stage_go_o          (go4),
        .stage_idx_o         (idx4),
        .instr_done_o        (done4),
        .halted_o            (halted4),
        .retired_count_o     (ret4),
        .last_instr_cycles_o (last4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_update();
        int nxt;
        if (nreset) begin
            m_mode = MStart; m_idx = 0; m_done = 0; m_ret = 0;
            m_cyc16 = 0; m_cyc4 = 0; m_last16 = 0; m_last4 = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                MStart: begin
                    m_mode = MRun;
                    m_idx  = 0;
                end
                MRun: begin
                    nxt = -1;
                    if (flush && FT > m_idx) begin
                        nxt = FT;
                    end else begin
                        for (int j = m_idx + 1; j < N; j++) begin
                            if (!skip_mask[j]) begin
                                nxt = j;
                                break;
                            end
                        end
                    end
                    if (nxt < 0) begin
                        m_ret    = (m_ret + 1) % 65536;
                        m_last16 = (m_cyc16 + 1) % 65536;
                        m_last4  = (m_cyc4 + 1) % 16;
                        m_cyc16  = 0;
                        m_cyc4   = 0;
                        m_done   = 1;
                        m_idx    = 0;
                        m_mode   = halt_req ? MHalt : MRun;
                    end else begin
                        if (m_cyc16 < 65535) m_cyc16++;
                        if (m_cyc4 < 15) m_cyc4++;
                        m_idx  = nxt;
                        m_mode = stall ? MStall : MRun;
                    end
                end
                MStall: begin
                    if (m_cyc16 < 65535) m_cyc16++;
                    if (m_cyc4 < 15) m_cyc4++;
                    if (!stall) m_mode = MRun;
                end
                default: begin
                    if (!halt_req) m_mode = MRun;
                end
            endcase
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] model_go();
        return (m_mode == MRun) ? (N'(1) << m_idx) : '0;
    endfunction

    task automatic test_reset();
        nreset = 1'b1; stall = 1'b0; flush = 1'b0; halt_req = 1'b0; skip_mask = '0;
        step();
        step();
        checks++;
        if (go !== 5'b0) begin errors++; $display("FAIL reset_go got %b want 00000", go); end
        checks++;
        if (idx !== 3'd0 || done !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got idx=%0d done=%b halted=%b want 0 0 0", idx, done, halted);
        end
        checks++;
        if (ret !== 16'd0 || last !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters got ret=%0d last=%0d want 0 0", ret, last);
        end
    endtask

    task automatic test_basic();
        nreset = 1'b0;
        for (int k = 0; k < N; k++) begin
            step();
            checks++;
            if (go !== (N'(1) << k)) begin
                errors++; $display("FAIL basic_go%0d got %b want %b", k, go, N'(1) << k);
            end
        end
        step();
        checks++;
        if (go !== 5'b00001 || done !== 1'b1) begin
            errors++; $display("FAIL basic_retire got go=%b done=%b want 00001 1", go, done);
        end
        checks++;
        if (ret !== 16'd1 || last !== 16'd5) begin
            errors++; $display("FAIL basic_counts got ret=%0d last=%0d want 1 5", ret, last);
        end
    endtask

    task automatic test_skip();
        logic [N-1:0] e [3];
        e = '{5'b00010, 5'b00100, 5'b10000};
        skip_mask = 5'b01000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (go !== e[k]) begin errors++; $display("FAIL skip_go%0d got %b want %b", k, go, e[k]); end
        end
        step();
        checks++;
        if (go !== 5'b00001 || last !== 16'd4) begin
            errors++; $display("FAIL skip_retire got go=%b last=%0d want 00001 4", go, last);
        end
        skip_mask = '0;
    endtask

    task automatic test_flush();
        step();
        flush = 1'b1;
        step();
        checks++;
        if (go !== 5'b10000) begin errors++; $display("FAIL flush_jump got %b want 10000", go); end
        flush = 1'b0;
        step();
        checks++;
        if (go !== 5'b00001 || last !== 16'd3) begin
            errors++; $display("FAIL flush_retire got go=%b last=%0d want 00001 3", go, last);
        end
        for (int k = 0; k < 4; k++) step();
        flush = 1'b1;
        step();
        checks++;
        if (go !== 5'b00001 || last !== 16'd5) begin
            errors++; $display("FAIL flush_at_last got go=%b last=%0d want 00001 5", go, last);
        end
        flush = 1'b0;
    endtask

    task automatic test_stall();
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (go !== 5'b0) begin errors++; $display("FAIL stall_hold%0d got %b want 00000", k, go); end
            if (k == 2) stall = 1'b0;
        end
        step();
        checks++;
        if (go !== 5'b01000) begin errors++; $display("FAIL stall_resume got %b want 01000", go); end
        step();
        step();
        checks++;
        if (go !== 5'b00001 || last !== 16'd8) begin
            errors++; $display("FAIL stall_retire got go=%b last=%0d want 00001 8", go, last);
        end
    endtask

    task automatic test_halt();
        step();
        step();
        halt_req = 1'b1;
        step();
        step();
        step();
        checks++;
        if (go !== 5'b0 || halted !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL halt_enter got go=%b halted=%b done=%b want 00000 1 1", go, halted, done);
        end
        step();
        checks++;
        if (halted !== 1'b1 || go !== 5'b0) begin
            errors++; $display("FAIL halt_hold got go=%b halted=%b want 00000 1", go, halted);
        end
        halt_req = 1'b0;
        step();
        checks++;
        if (go !== 5'b00001 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_leave got go=%b halted=%b want 00001 0", go, halted);
        end
        for (int k = 0; k < 4; k++) step();
        halt_req = 1'b1;
        stall    = 1'b1;
        step();
        checks++;
        if (halted !== 1'b1 || go !== 5'b0) begin
            errors++; $display("FAIL halt_beats_stall got go=%b halted=%b want 00000 1", go, halted);
        end
        halt_req = 1'b0;
        stall    = 1'b0;
        step();
        checks++;
        if (go !== 5'b00001) begin errors++; $display("FAIL halt_stall_leave got %b want 00001", go); end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        step();
        nreset = 1'b1;
        step();
        checks++;
        if (go !== 5'b0 || ret !== 16'd0 || last !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got go=%b ret=%0d last=%0d halted=%b want 00000 0 0 0",
                     go, ret, last, halted);
        end
        nreset = 1'b0;
        step();
        checks++;
        if (go !== 5'b00001) begin errors++; $display("FAIL reset_mid_restart got %b want 00001", go); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 16 * N; k++) step();
        checks++;
        if (ret4 !== 4'd0 || ret !== 16'd16) begin
            errors++; $display("FAIL wrap got ret4=%0d ret=%0d want 0 16", ret4, ret);
        end
    endtask

    task automatic test_random();
        int stall_pct;
        stall_pct = 20;
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) stall_pct = ($urandom_range(1) == 0) ? 20 : 92;
            nreset    = ($urandom_range(199) == 0);
            stall     = ($urandom_range(99) < stall_pct);
            flush     = ($urandom_range(5) == 0);
            halt_req  = ($urandom_range(9) == 0);
            skip_mask = N'($urandom);
            step();
            checks++;
            if (go !== model_go() || go4 !== model_go()) begin
                errors++; $display("FAIL rand_go c=%0d got %b/%b want %b", c, go, go4, model_go());
            end
            checks++;
            if (idx !== 3'(m_idx) || idx4 !== 3'(m_idx)) begin
                errors++; $display("FAIL rand_idx c=%0d got %0d/%0d want %0d", c, idx, idx4, m_idx);
            end
            checks++;
            if (done !== 1'(m_done) || halted !== (m_mode == MHalt) || halted4 !== (m_mode == MHalt)
                || done4 !== 1'(m_done)) begin
                errors++;
                $display("FAIL rand_flags c=%0d got done=%b halted=%b want %0d %0d",
                         c, done, halted, m_done, m_mode == MHalt);
            end
            checks++;
            if (ret !== 16'(m_ret) || last !== 16'(m_last16)) begin
                errors++;
                $display("FAIL rand_cnt16 c=%0d got ret=%0d last=%0d want %0d %0d",
                         c, ret, last, m_ret, m_last16);
            end
            checks++;
            if (ret4 !== 4'(m_ret % 16) || last4 !== 4'(m_last4)) begin
                errors++;
                $display("FAIL rand_cnt4 c=%0d got ret=%0d last=%0d want %0d %0d",
                         c, ret4, last4, m_ret % 16, m_last4);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_mode = MStart; m_idx = 0; m_done = 0; m_ret = 0;
        m_cyc16 = 0; m_cyc4 = 0; m_last16 = 0; m_last4 = 0;
        test_reset();
        test_basic();
        test_skip();
        test_flush();
        test_stall();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
